// File: rtl/physics_step_sequencer_pkg.sv
// ============================================================================
// Module   : bounce_pkg
// Brief    : Op codes, sequencer state encoding and q8.24 format constants
//            shared by the bouncing-LED physics step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bounce_pkg;

    typedef logic [2:0] op_code_t;

    localparam op_code_t OP_NOP       = 3'd0;
    localparam op_code_t OP_INIT      = 3'd1;
    localparam op_code_t OP_KICK      = 3'd2;
    localparam op_code_t OP_GRAVITY   = 3'd3;
    localparam op_code_t OP_INTEGRATE = 3'd4;
    localparam op_code_t OP_COLLIDE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_GRAV  = 3'd2,
        ST_INTEG = 3'd3,
        ST_COLL  = 3'd4,
        ST_KICK  = 3'd5
    } state_t;

    localparam int FRAC_BITS = 24;
    localparam int INT_BITS  = 8;
    localparam int Q_WIDTH   = INT_BITS + FRAC_BITS;

    function automatic op_code_t op_of_state(input state_t s);
        op_code_t op;
        case (s)
            ST_INIT:  op = OP_INIT;
            ST_GRAV:  op = OP_GRAVITY;
            ST_INTEG: op = OP_INTEGRATE;
            ST_COLL:  op = OP_COLLIDE;
            ST_KICK:  op = OP_KICK;
            default:  op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/physics_step_sequencer_if.sv
// ============================================================================
// Module   : physics_step_sequencer_if
// Brief    : Op handshake between the step sequencer (master) and the
//            position/velocity datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface physics_step_sequencer_if;

    logic                 op_valid;
    bounce_pkg::op_code_t op_code;
    logic                 delta_sel;
    logic                 op_ready;

    modport master (output op_valid, output op_code, output delta_sel, input  op_ready);
    modport slave  (input  op_valid, input  op_code, input  delta_sel, output op_ready);

endinterface

`default_nettype wire

// File: rtl/physics_step_sequencer_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating counter; counts up to all-ones, or (DOWN=1) down to
//            zero, with synchronous clear and load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 8,
    parameter bit DOWN  = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    output logic      [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            if (DOWN) begin
                if (r_count != '0) r_count <= r_count - 1'b1;
            end else begin
                if (r_count != '1) r_count <= r_count + 1'b1;
            end
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/physics_step_sequencer.sv
// ============================================================================
// Module   : physics_step_sequencer
// Brief    : Arbitrates init / step tick / kick requests and issues one
//            datapath op at a time. Define KICK_RATE_LIMIT_EN for kick holdoff.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module physics_step_sequencer
    import bounce_pkg::*;
#(
    parameter int KICK_HOLDOFF = 64,
    parameter int OVR_W        = 8
) (
    input  wire logic                CLOCK_50,
    input  wire logic                Reset,
    input  wire logic                tick,
    input  wire logic                kick_req,
    input  wire logic                init_req,
    physics_step_sequencer_if.master op_bus,
    output logic                     busy,
    output logic         [OVR_W-1:0] overrun_cnt
);

    if (KICK_HOLDOFF < 1 || OVR_W < 1) begin : g_param_check
        $error("physics_step_sequencer: KICK_HOLDOFF and OVR_W must be >= 1");
    end

    state_t   r_state;
    state_t   w_next_state;
    logic     r_op_valid;
    op_code_t r_op_code;
    logic     r_delta_sel;
    logic     r_busy;
    logic     r_tick_pend;
    logic     r_kick_pend;
    logic     r_init_pend;
    logic     w_accept;
    logic     w_init_now;
    logic     w_go_init;
    logic     w_clr_tick;
    logic     w_clr_kick;
    logic     w_kick_ok;
    logic     w_overrun_inc;

    assign w_accept   = r_op_valid && op_bus.op_ready;
    // An init seen anywhere during the current op diverts the chain at its handshake
    assign w_init_now = init_req || r_init_pend;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (init_req)         w_next_state = ST_INIT;
                else if (r_tick_pend) w_next_state = ST_GRAV;
                else if (r_kick_pend) w_next_state = ST_KICK;
            end
            ST_INIT:  if (w_accept) w_next_state = ST_IDLE;
            ST_GRAV:  if (w_accept) w_next_state = w_init_now ? ST_INIT : ST_INTEG;
            ST_INTEG: if (w_accept) w_next_state = w_init_now ? ST_INIT : ST_COLL;
            ST_COLL:  if (w_accept) w_next_state = w_init_now ? ST_INIT : ST_IDLE;
            ST_KICK:  if (w_accept) w_next_state = w_init_now ? ST_INIT : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign w_go_init     = (w_next_state == ST_INIT) && (r_state != ST_INIT);
    assign w_clr_tick    = w_go_init || ((r_state == ST_IDLE) && (w_next_state == ST_GRAV));
    assign w_clr_kick    = w_go_init || ((r_state == ST_IDLE) && (w_next_state == ST_KICK));
    assign w_overrun_inc = tick && r_tick_pend && !w_clr_tick;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_op_valid  <= 1'b0;
            r_op_code   <= OP_NOP;
            r_delta_sel <= 1'b0;
            r_busy      <= 1'b0;
            r_tick_pend <= 1'b0;
            r_kick_pend <= 1'b0;
            r_init_pend <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_op_valid <= (w_next_state != ST_IDLE);
            r_op_code  <= op_of_state(w_next_state);
            r_busy     <= (w_next_state != ST_IDLE);
            if (w_accept && (r_state == ST_INIT))
                r_delta_sel <= 1'b0;
            else if (w_accept && (r_state == ST_GRAV))
                r_delta_sel <= ~r_delta_sel;
            // A pulse in the dispatch cycle re-arms its flag
            r_tick_pend <= tick || (r_tick_pend && !w_clr_tick);
            r_kick_pend <= (kick_req && w_kick_ok) || (r_kick_pend && !w_clr_kick);
            r_init_pend <= !w_go_init && (r_init_pend ||
                           (init_req && (r_state != ST_IDLE) && (r_state != ST_INIT)));
        end
    end

    sat_counter #(
        .WIDTH (OVR_W),
        .DOWN  (1'b0)
    ) u_overrun (
        .clk      (CLOCK_50),
        .rst      (Reset),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .en       (w_overrun_inc),
        .count    (overrun_cnt)
    );

`ifdef KICK_RATE_LIMIT_EN
    localparam int c_HO_W = (KICK_HOLDOFF < 2) ? 1 : $clog2(KICK_HOLDOFF + 1);

    logic [c_HO_W-1:0] w_holdoff;

    sat_counter #(
        .WIDTH (c_HO_W),
        .DOWN  (1'b1)
    ) u_holdoff (
        .clk      (CLOCK_50),
        .rst      (Reset),
        .clr      (w_accept && (r_state == ST_INIT)),
        .load     (w_accept && (r_state == ST_KICK)),
        .load_val (c_HO_W'(KICK_HOLDOFF)),
        .en       (w_accept && (r_state == ST_COLL)),
        .count    (w_holdoff)
    );

    assign w_kick_ok = (w_holdoff == '0);
`else
    assign w_kick_ok = 1'b1;
`endif

    assign op_bus.op_valid  = r_op_valid;
    assign op_bus.op_code   = r_op_code;
    assign op_bus.delta_sel = r_delta_sel;
    assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_physics_step_sequencer.sv
// ============================================================================
// Module   : tb_physics_step_sequencer
// Brief    : Directed and random stimulus against an op-level reference model
//            with a decoupled scoreboard of issued ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_physics_step_sequencer;

    localparam int OVR_W   = 8;
    localparam int KH      = 2;
    localparam int OVR_MAX = (1 << OVR_W) - 1;
    localparam int NOP = 0, INIT = 1, KICK = 2, GRAV = 3, INTEG = 4, COLL = 5;

    logic             CLOCK_50 = 1'b0;
    logic             Reset    = 1'b1;
    logic             tick     = 1'b0;
    logic             kick_req = 1'b0;
    logic             init_req = 1'b0;
    logic             busy;
    logic [OVR_W-1:0] overrun_cnt;

    physics_step_sequencer_if bus ();

    physics_step_sequencer #(
        .KICK_HOLDOFF (KH),
        .OVR_W        (OVR_W)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .Reset       (Reset),
        .tick        (tick),
        .kick_req    (kick_req),
        .init_req    (init_req),
        .op_bus      (bus),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: current op (0 = idle), ops still owed by the step chain,
    // pending requests and counters, advanced once per clock from sampled inputs.
    int cur, ovr, hold;
    bit tp, kp, ip, dsel;
    int chain[$];
    int sbq[$];

    always @(negedge CLOCK_50) begin : model
        bit tk, kk, ini, rdy, acc, ct, ck, kick_ok;
        int nxt, hold_now;
        if (Reset) begin
            cur = NOP; ovr = 0; hold = 0;
            tp = 0; kp = 0; ip = 0; dsel = 0;
            chain.delete();
            sbq.delete();
        end else begin
            check("outputs{valid,code,dsel,busy,ovr}",
                  int'({bus.op_valid, bus.op_code, bus.delta_sel, busy, overrun_cnt}),
                  ((cur != NOP) << 13) | (cur << 10) | (int'(dsel) << 9) |
                  ((cur != NOP) << 8) | ovr);
            tk = tick; kk = kick_req; ini = init_req; rdy = bus.op_ready;
            hold_now = hold;
            acc = (cur != NOP) && rdy;
            ct = 0; ck = 0;
            nxt = cur;
            if (cur == NOP) begin
                if (ini) begin
                    nxt = INIT; chain.delete(); ct = 1; ck = 1;
                end else if (tp) begin
                    nxt = GRAV; chain = '{INTEG, COLL}; ct = 1;
                end else if (kp) begin
                    nxt = KICK; ck = 1;
                end
            end else if (acc) begin
                if (cur == GRAV) dsel = !dsel;
                if (cur == INIT) begin dsel = 0; hold = 0; end
                if (cur == KICK) hold = KH;
                if (cur == COLL && hold > 0) hold--;
                if (cur != INIT && (ini || ip)) begin
                    nxt = INIT; chain.delete(); ct = 1; ck = 1;
                end else if (chain.size() > 0) begin
                    nxt = chain.pop_front();
                end else begin
                    nxt = NOP;
                end
            end
            if (nxt == INIT && cur != INIT) ip = 0;
            else if (ini && cur != NOP && cur != INIT) ip = 1;
            if (tk && tp && !ct && ovr < OVR_MAX) ovr++;
`ifdef KICK_RATE_LIMIT_EN
            kick_ok = (hold_now == 0);
`else
            kick_ok = 1;
`endif
            tp = tk || (tp && !ct);
            kp = (kk && kick_ok) || (kp && !ck);
            if (nxt != NOP && (cur == NOP || acc)) sbq.push_back(nxt * 2 + int'(dsel));
            cur = nxt;
        end
    end

    always @(negedge CLOCK_50) begin : monitor
        if (!Reset && bus.op_valid && bus.op_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_op t=%0t actual=op%0d required=no_op", $time, bus.op_code);
            end else begin
                check("sb_op{code,dsel}", int'({bus.op_code, bus.delta_sel}), sbq.pop_front());
            end
        end
    end

    task automatic cyc(input bit tk, input bit kk, input bit ini, input bit rdy);
        @(posedge CLOCK_50);
        #1;
        tick = tk; kick_req = kk; init_req = ini; bus.op_ready = rdy;
    endtask

    initial begin
        bus.op_ready = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_op_valid", bus.op_valid, 0);
        check("reset_op_code", bus.op_code, NOP);
        check("reset_delta_sel", bus.delta_sel, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun_cnt, 0);
        Reset = 1'b0;

        // single tick, ready always high
        cyc(1, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);

        // tick and kick together: step chain first, kick afterwards
        cyc(1, 1, 0, 1);
        repeat (10) cyc(0, 0, 0, 1);

        // GRAVITY stalled 5 cycles with two extra ticks
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (15) cyc(0, 0, 0, 1);
        check("overrun_after_stall", overrun_cnt, 1);

        // init during INTEGRATE, ready delayed two cycles, kick pending too
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1);
        @(negedge CLOCK_50);
        check("init_delta_sel_cleared", bus.delta_sel, 0);
        check("init_pending_cleared_idle", busy, 0);

        // kick / step / kick / step / kick (holdoff behaviour depends on build)
        cyc(0, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        repeat (4) cyc(0, 0, 0, 1);

        // asynchronous reset between edges while GRAVITY is presented
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        #5;
        Reset = 1'b1;
        #1;
        check("async_reset_op_valid", bus.op_valid, 0);
        check("async_reset_overrun", overrun_cnt, 0);
        check("async_reset_busy", busy, 0);
        @(posedge CLOCK_50);
        #1;
        Reset = 1'b0;

        // overlapping ticks with ready low saturate the overrun counter
        repeat (300) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge CLOCK_50);
        check("overrun_saturated", overrun_cnt, OVR_MAX);
        repeat (10) cyc(0, 0, 0, 1);

        // random traffic
        repeat (1500)
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);

        repeat (20) cyc(0, 0, 0, 1);
        @(negedge CLOCK_50);
        check("scoreboard_drained", sbq.size(), 0);
        check("idle_at_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
